// File: rtl/grid_cell_locator_if.sv
// Scan-position / board-state bundle between the VGA sync counter and the drawing logic.
// The master drives the scan position and board; the slave (locator) returns the cell lookup.
interface grid_cell_locator_if #(
  parameter int unsigned ROWS = 3,
  parameter int unsigned COLS = 3,
  parameter int unsigned PW   = 10
);
  logic [PW-1:0]          pixelx;
  logic [PW-1:0]          pixely;
  logic                   frame_start;
  logic [2*ROWS*COLS-1:0] board;
  logic [1:0]             match_owner;

  logic                   in_grid;
  logic [5:0]             cell_idx;
  logic [1:0]             cell_owner;
  logic                   match_hit;
  logic [PW-1:0]          posx;
  logic [PW-1:0]          posy;
  logic [6:0]             match_count;

  modport master (
    output pixelx, pixely, frame_start, board, match_owner,
    input  in_grid, cell_idx, cell_owner, match_hit, posx, posy, match_count
  );

  modport slave (
    input  pixelx, pixely, frame_start, board, match_owner,
    output in_grid, cell_idx, cell_owner, match_hit, posx, posy, match_count
  );
endinterface

// File: rtl/grid_cell_locator.sv
// Maps the scan position to a cell of a ROWS x COLS board, looks up its owner, tracks the
// centre of the last cell owned by match_owner and counts such cells per frame.
module grid_cell_locator #(
  parameter int unsigned ROWS = 3,
  parameter int unsigned COLS = 3,
  parameter int unsigned X0   = 96,
  parameter int unsigned Y0   = 2,
  parameter int unsigned CW   = 240,
  parameter int unsigned CH   = 172,
  parameter int unsigned PW   = 10
) (
  input logic               clock,
  input logic               reset,
  grid_cell_locator_if.slave bus
);
  localparam int unsigned NCELL = ROWS * COLS;
  localparam int unsigned XEND  = X0 + COLS * CW;
  localparam int unsigned YEND  = Y0 + ROWS * CH;

  if (ROWS < 1 || ROWS > 8 || COLS < 1 || COLS > 8) begin : g_bad_dims
    $error("grid_cell_locator: ROWS and COLS must lie in 1..8");
  end
  if (XEND > (2 ** PW) - 1 || YEND > (2 ** PW) - 1) begin : g_bad_extent
    $error("grid_cell_locator: grid extent does not fit in PW bits");
  end

  // Thermometer of "coordinate >= boundary k"; bit 0 is the grid start, bit COLS/ROWS the end.
  logic [COLS:0] x_ge;
  logic [ROWS:0] y_ge;

  for (genvar c = 0; c <= COLS; c++) begin : g_xcmp
    assign x_ge[c] = bus.pixelx >= PW'(X0 + c * CW);
  end
  for (genvar r = 0; r <= ROWS; r++) begin : g_ycmp
    assign y_ge[r] = bus.pixely >= PW'(Y0 + r * CH);
  end

  logic [2:0] col_d, col_q, row_d, row_q;
  logic       inr_d, inr_q;

  always_comb begin
    col_d = '0;
    row_d = '0;
    for (int c = 1; c < COLS; c++) if (x_ge[c]) col_d = 3'(c);
    for (int r = 1; r < ROWS; r++) if (y_ge[r]) row_d = 3'(r);
    inr_d = x_ge[0] & ~x_ge[COLS] & y_ge[0] & ~y_ge[ROWS];
  end

  logic [5:0]    idx_d, idx_q;
  logic [1:0]    owner_d, owner_q;
  logic          hit_d, hit_q, in_grid_q;
  logic [PW-1:0] cx_d, cy_d, posx_q, posy_q;

  always_comb begin
    idx_d   = '0;
    owner_d = '0;
    if (inr_q) begin
      idx_d   = 6'(32'(row_q) * COLS + 32'(col_q));
      owner_d = 2'(bus.board >> {idx_d, 1'b0});
    end
    hit_d = inr_q && (owner_d == bus.match_owner);
    cx_d  = PW'(X0 + CW / 2 + 32'(col_q) * CW);
    cy_d  = PW'(Y0 + CH / 2 + 32'(row_q) * CH);
  end

  logic [NCELL-1:0] mask_d, mask_q, cell_bit;
  logic [6:0]       acc_d, acc_q, count_d, count_q;

  assign cell_bit = NCELL'(1) << idx_q;

  // A hit coinciding with frame_start is cleared first, then counted into the new frame.
  always_comb begin
    acc_d   = acc_q;
    mask_d  = mask_q;
    count_d = count_q;
    if (bus.frame_start) begin
      count_d = acc_q;
      acc_d   = '0;
      mask_d  = '0;
    end
    if (hit_q && ((mask_d & cell_bit) == '0)) begin
      mask_d = mask_d | cell_bit;
      acc_d  = acc_d + 7'd1;
    end
  end

  always_ff @(negedge clock) begin
    if (reset) begin
      col_q     <= '0;
      row_q     <= '0;
      inr_q     <= 1'b0;
      idx_q     <= '0;
      owner_q   <= '0;
      hit_q     <= 1'b0;
      in_grid_q <= 1'b0;
      posx_q    <= '0;
      posy_q    <= '0;
      acc_q     <= '0;
      mask_q    <= '0;
      count_q   <= '0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      inr_q     <= inr_d;
      idx_q     <= idx_d;
      owner_q   <= owner_d;
      hit_q     <= hit_d;
      in_grid_q <= inr_q;
      if (hit_d) begin
        posx_q <= cx_d;
        posy_q <= cy_d;
      end
      acc_q     <= acc_d;
      mask_q    <= mask_d;
      count_q   <= count_d;
    end
  end

  assign bus.in_grid     = in_grid_q;
  assign bus.cell_idx    = idx_q;
  assign bus.cell_owner  = owner_q;
  assign bus.match_hit   = hit_q;
  assign bus.posx        = posx_q;
  assign bus.posy        = posy_q;
  assign bus.match_count = count_q;
endmodule

// File: tb/tb_grid_cell_locator.sv
// Randomised and directed bench for grid_cell_locator against a cell-arithmetic reference model.
module tb_grid_cell_locator;
  localparam int X0 = 96, Y0 = 2, CW = 240, CH = 172, ROWS = 3, COLS = 3;

  logic clock;
  logic reset;

  grid_cell_locator_if #(.ROWS(3), .COLS(3), .PW(10)) ifa ();
  grid_cell_locator_if #(.ROWS(4), .COLS(5), .PW(10)) ifb ();

  grid_cell_locator dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (ifa)
  );

  grid_cell_locator #(.ROWS(4), .COLS(5), .CW(100), .CH(100)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (ifb)
  );

  initial clock = 1'b1;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Stimulus state
  bit        rst;
  logic [17:0] brd;
  logic [1:0]  mo;

  // Reference model state
  int       m_x, m_y;
  bit       e_in, e_hit;
  int       e_idx, e_own, e_px, e_py, e_cnt, e_acc;
  bit [63:0] seen;

  task automatic model_edge(input int x, input int y, input bit fs);
    int col, row;
    if (rst) begin
      e_in = 0; e_hit = 0; e_idx = 0; e_own = 0; e_px = 0; e_py = 0;
      e_cnt = 0; e_acc = 0; seen = '0; m_x = 0; m_y = 0;
    end else begin
      if (fs) begin
        e_cnt = e_acc; e_acc = 0; seen = '0;
      end
      if (e_hit && !seen[e_idx]) begin
        seen[e_idx] = 1'b1;
        e_acc++;
      end
      if (m_x >= X0 && m_x < X0 + COLS * CW && m_y >= Y0 && m_y < Y0 + ROWS * CH) begin
        col   = (m_x - X0) / CW;
        row   = (m_y - Y0) / CH;
        e_in  = 1;
        e_idx = row * COLS + col;
        e_own = int'((brd >> (2 * e_idx)) & 18'd3);
        e_hit = (e_own == int'(mo));
        if (e_hit) begin
          e_px = X0 + col * CW + CW / 2;
          e_py = Y0 + row * CH + CH / 2;
        end
      end else begin
        e_in = 0; e_hit = 0; e_idx = 0; e_own = 0;
      end
      m_x = x;
      m_y = y;
    end
  endtask

  task automatic cyc(input int x, input int y, input bit fs);
    ifa.pixelx      = 10'(x);
    ifa.pixely      = 10'(y);
    ifa.frame_start = fs;
    ifa.board       = brd;
    ifa.match_owner = mo;
    reset           = rst;
    @(negedge clock);
    model_edge(x, y, fs);
    #1;
    check("in_grid", ifa.in_grid, e_in);
    check("cell_idx", ifa.cell_idx, e_idx);
    check("cell_owner", ifa.cell_owner, e_own);
    check("match_hit", ifa.match_hit, e_hit);
    check("posx", ifa.posx, e_px);
    check("posy", ifa.posy, e_py);
    check("match_count", ifa.match_count, e_cnt);
  endtask

  // Present one pixel, then a blank pixel, so outputs reflect the first one.
  task automatic probe(input int x, input int y);
    cyc(x, y, 1'b0);
    cyc(1000, 1000, 1'b0);
  endtask

  task automatic scan(input int abort_acc);
    for (int y = 0; y <= 528; y += 12) begin
      for (int x = 0; x <= 820; x += 20) begin
        cyc(x, y, 1'b0);
        if (abort_acc != 0 && e_acc >= abort_acc) return;
      end
    end
    repeat (4) cyc(1000, 1000, 1'b0);
  endtask

  initial begin
    rst = 1; brd = '0; mo = 2'b10;
    ifb.pixelx = 10'd501; ifb.pixely = 10'd307; ifb.frame_start = 1'b0;
    ifb.board = '0; ifb.board[39:38] = 2'b10; ifb.match_owner = 2'b10;

    repeat (3) cyc(0, 0, 1'b0);
    check("reset_posx", ifa.posx, 0);
    check("reset_count", ifa.match_count, 0);
    rst = 0;

    brd = 18'h00002;
    probe(100, 10);
    check("dir_in_grid", ifa.in_grid, 1);
    check("dir_idx", ifa.cell_idx, 0);
    check("dir_hit", ifa.match_hit, 1);
    check("dir_posx", ifa.posx, 216);
    check("dir_posy", ifa.posy, 88);

    probe(335, 10); check("bnd_335", ifa.cell_idx, 0);
    probe(336, 10); check("bnd_336", ifa.cell_idx, 1);
    probe(95, 10);  check("bnd_95", ifa.in_grid, 0);
    probe(816, 10); check("bnd_816", ifa.in_grid, 0);

    brd = 18'h00102;
    probe(100, 10);
    probe(450, 200);
    check("nm_idx", ifa.cell_idx, 4);
    check("nm_hit", ifa.match_hit, 0);
    check("nm_posx", ifa.posx, 216);
    check("nm_posy", ifa.posy, 88);

    // Cells 0, 4, 8 owned by player 2.
    brd = (18'd2 << 0) | (18'd2 << 8) | (18'd2 << 16);
    repeat (4) cyc(1000, 1000, 1'b0);
    cyc(0, 0, 1'b1);
    scan(0);
    cyc(0, 0, 1'b1);
    check("frame_count3", ifa.match_count, 3);

    scan(2);
    rst = 1;
    cyc(1000, 1000, 1'b0);
    cyc(1000, 1000, 1'b0);
    check("midrst_posx", ifa.posx, 0);
    check("midrst_hit", ifa.match_hit, 0);
    check("midrst_count", ifa.match_count, 0);
    rst = 0;
    repeat (4) cyc(1000, 1000, 1'b0);
    cyc(0, 0, 1'b1);
    check("post_rst_count", ifa.match_count, 0);

    for (int f = 0; f < 3; f++) begin
      brd = 18'($urandom);
      mo  = 2'($urandom_range(2, 0));
      scan(0);
      cyc(0, 0, 1'b1);
    end

    for (int i = 0; i < 800; i++) begin
      if (i % 50 == 0) begin
        brd = 18'($urandom);
        mo  = 2'($urandom);
      end
      cyc(int'($urandom_range(830, 60)), int'($urandom_range(540, 0)),
          $urandom_range(63, 0) == 0);
    end

    check("b_in_grid", ifb.in_grid, 1);
    check("b_idx", ifb.cell_idx, 19);
    check("b_hit", ifb.match_hit, 1);
    check("b_posx", ifb.posx, 546);
    check("b_posy", ifb.posy, 352);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
